microwave_cook_controller: RTL and testbench

- Sequences a cooking cycle from the three BCD digits produced by the keypad timer-entry block.
- Loads the entered time and counts it down on a 1 Hz tick while driving the magnetron enable.
- Handles pause/resume on door open or stop, raises the end-of-cook alarm, and clears the entry block when a cycle is abandoned or finished.
- Sits between the timer-entry block, the front-panel buttons and door switch, and the display/magnetron drivers.

---
 rtl/microwave_cook_controller.sv | 177 +++++++++++++++++
 tb/tb_microwave_cook_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_controller.sv
// rtl/microwave_cook_controller.sv - cook-cycle sequencer: BCD countdown, magnetron enable, pause/resume, alarm
module microwave_cook_controller #(
    parameter int ALARM_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic [3:0] units_of_seconds,
    input  logic [3:0] tens_of_seconds,
    input  logic [3:0] units_of_minutes,
    output logic [3:0] rem_sec_units,
    output logic [3:0] rem_sec_tens,
    output logic [3:0] rem_min_units,
    output logic       mag_on,
    output logic       lamp_on,
    output logic       alarm,
    output logic       entry_clr,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COOKING = 2'b01,
        S_PAUSED  = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam logic [3:0] ALARM_CNT = 4'(ALARM_SECS);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_su, r_st, r_mu;
    logic [3:0] w_su_nxt, w_st_nxt, w_mu_nxt;
    logic       r_mag, w_mag_nxt;
    logic       r_alarm, w_alarm_nxt;
    logic       r_clr, w_clr_req;
    logic [3:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    logic [3:0] w_in_su, w_in_st, w_in_mu;
    logic       w_in_zero;
    assign w_in_su   = clamp9(units_of_seconds);
    assign w_in_st   = clamp9(tens_of_seconds);
    assign w_in_mu   = clamp9(units_of_minutes);
    assign w_in_zero = (w_in_su == 4'd0) && (w_in_st == 4'd0) && (w_in_mu == 4'd0);

    // One-second BCD decrement; tens borrow reloads 5 so 0:90 style entries still count down correctly.
    logic [3:0] w_dec_su, w_dec_st, w_dec_mu;
    logic       w_rem_zero, w_dec_zero;
    always_comb begin
        w_dec_su = r_su;
        w_dec_st = r_st;
        w_dec_mu = r_mu;
        if (r_su != 4'd0) begin
            w_dec_su = r_su - 4'd1;
        end else if (r_st != 4'd0) begin
            w_dec_st = r_st - 4'd1;
            w_dec_su = 4'd9;
        end else if (r_mu != 4'd0) begin
            w_dec_mu = r_mu - 4'd1;
            w_dec_st = 4'd5;
            w_dec_su = 4'd9;
        end
    end
    assign w_rem_zero = (r_su == 4'd0) && (r_st == 4'd0) && (r_mu == 4'd0);
    assign w_dec_zero = (w_dec_su == 4'd0) && (w_dec_st == 4'd0) && (w_dec_mu == 4'd0);
    assign w_cnt_inc  = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_su_nxt    = r_su;
        w_st_nxt    = r_st;
        w_mu_nxt    = r_mu;
        w_mag_nxt   = r_mag;
        w_alarm_nxt = r_alarm;
        w_cnt_nxt   = r_cnt;
        w_clr_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_su_nxt    = w_in_su;
                w_st_nxt    = w_in_st;
                w_mu_nxt    = w_in_mu;
                w_mag_nxt   = 1'b0;
                w_alarm_nxt = 1'b0;
                if (stop) begin
                    w_clr_req = 1'b1;
                end else if (start && door_closed && !w_in_zero) begin
                    w_state_nxt = S_COOKING;
                    w_mag_nxt   = 1'b1;
                end
            end
            S_COOKING: begin
                if (!door_closed || stop) begin
                    w_state_nxt = S_PAUSED;
                    w_mag_nxt   = 1'b0;
                end else if (tick_1hz) begin
                    if (w_rem_zero || w_dec_zero) begin
                        w_state_nxt = S_DONE;
                        w_su_nxt    = 4'd0;
                        w_st_nxt    = 4'd0;
                        w_mu_nxt    = 4'd0;
                        w_mag_nxt   = 1'b0;
                        w_alarm_nxt = 1'b1;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_su_nxt = w_dec_su;
                        w_st_nxt = w_dec_st;
                        w_mu_nxt = w_dec_mu;
                    end
                end
            end
            S_PAUSED: begin
                w_mag_nxt = 1'b0;
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_su_nxt    = 4'd0;
                    w_st_nxt    = 4'd0;
                    w_mu_nxt    = 4'd0;
                    w_clr_req   = 1'b1;
                end else if (start && door_closed) begin
                    w_state_nxt = S_COOKING;
                    w_mag_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_mag_nxt = 1'b0;
                if (start || stop || (tick_1hz && (w_cnt_inc >= ALARM_CNT))) begin
                    w_state_nxt = S_IDLE;
                    w_alarm_nxt = 1'b0;
                    w_cnt_nxt   = 4'd0;
                    w_clr_req   = 1'b1;
                end else if (tick_1hz) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_su    <= 4'd0;
            r_st    <= 4'd0;
            r_mu    <= 4'd0;
            r_mag   <= 1'b0;
            r_alarm <= 1'b0;
            r_clr   <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_su    <= w_su_nxt;
            r_st    <= w_st_nxt;
            r_mu    <= w_mu_nxt;
            r_mag   <= w_mag_nxt;
            r_alarm <= w_alarm_nxt;
            // Suppressing back-to-back requests keeps the clear a clean single pulse.
            r_clr   <= w_clr_req & ~r_clr;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign rem_sec_units = r_su;
    assign rem_sec_tens  = r_st;
    assign rem_min_units = r_mu;
    assign mag_on        = r_mag;
    assign alarm         = r_alarm;
    assign entry_clr     = r_clr;
    assign state         = r_state;
    assign lamp_on       = !door_closed || (r_state == S_COOKING);

endmodule

// File: tb/tb_microwave_cook_controller.sv
// tb/tb_microwave_cook_controller.sv - directed self-checking bench for microwave_cook_controller
module tb_microwave_cook_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] units_of_seconds = 4'd0;
    logic [3:0] tens_of_seconds = 4'd0;
    logic [3:0] units_of_minutes = 4'd0;
    logic [3:0] rem_sec_units, rem_sec_tens, rem_min_units;
    logic       mag_on, lamp_on, alarm, entry_clr;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] IDLE = 2'b00, COOKING = 2'b01, PAUSED = 2'b10, DONE = 2'b11;

    microwave_cook_controller #(.ALARM_SECS(3)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .stop(stop),
        .door_closed(door_closed), .units_of_seconds(units_of_seconds),
        .tens_of_seconds(tens_of_seconds), .units_of_minutes(units_of_minutes),
        .rem_sec_units(rem_sec_units), .rem_sec_tens(rem_sec_tens), .rem_min_units(rem_min_units),
        .mag_on(mag_on), .lamp_on(lamp_on), .alarm(alarm), .entry_clr(entry_clr), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic entry(input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
        units_of_minutes = mu;
        tens_of_seconds  = st;
        units_of_seconds = su;
    endtask

    task automatic pulse(input logic p_start, input logic p_stop, input logic p_tick);
        start = p_start; stop = p_stop; tick_1hz = p_tick;
        cyc();
        start = 1'b0; stop = 1'b0; tick_1hz = 1'b0;
    endtask

    function automatic logic [15:0] rem();
        return {4'd0, rem_min_units, rem_sec_tens, rem_sec_units};
    endfunction

    initial begin
        // Reset state
        #2;
        chk("rst_state", 16'(state), 16'(IDLE));
        chk("rst_rem", rem(), 16'h0000);
        chk("rst_mag", 16'(mag_on), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        chk("rst_clr", 16'(entry_clr), 16'd0);
        chk("rst_lamp_closed", 16'(lamp_on), 16'd0);
        #10 rst = 1'b1;
        cyc();

        // 0:05 full cycle through DONE and alarm timeout
        entry(4'd0, 4'd0, 4'd5);
        cyc();
        chk("idle_mirror_005", rem(), 16'h0005);
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_state", 16'(state), 16'(COOKING));
        chk("start_mag", 16'(mag_on), 16'd1);
        chk("start_lamp", 16'(lamp_on), 16'd1);
        pulse(1'b0, 1'b0, 1'b1); chk("t1", rem(), 16'h0004);
        pulse(1'b0, 1'b0, 1'b1); chk("t2", rem(), 16'h0003);
        cyc();                   chk("no_tick_hold", rem(), 16'h0003);
        pulse(1'b0, 1'b0, 1'b1); chk("t3", rem(), 16'h0002);
        pulse(1'b0, 1'b0, 1'b1); chk("t4", rem(), 16'h0001);
        chk("t4_cooking", 16'(state), 16'(COOKING));
        pulse(1'b0, 1'b0, 1'b1);
        chk("t5_rem", rem(), 16'h0000);
        chk("t5_done", 16'(state), 16'(DONE));
        chk("t5_alarm", 16'(alarm), 16'd1);
        chk("t5_mag", 16'(mag_on), 16'd0);
        pulse(1'b0, 1'b0, 1'b1); chk("a1_done", 16'(state), 16'(DONE));
        pulse(1'b0, 1'b0, 1'b1); chk("a2_alarm", 16'(alarm), 16'd1);
        chk("a2_clr", 16'(entry_clr), 16'd0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("a3_idle", 16'(state), 16'(IDLE));
        chk("a3_alarm", 16'(alarm), 16'd0);
        chk("a3_clr", 16'(entry_clr), 16'd1);
        cyc();
        chk("a3_clr_once", 16'(entry_clr), 16'd0);

        // Borrow from minutes; tens >= 6
        entry(4'd1, 4'd0, 4'd0);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("borrow_100", rem(), 16'h0059);
        pulse(1'b0, 1'b1, 1'b0);
        chk("stop1_paused", 16'(state), 16'(PAUSED));
        pulse(1'b0, 1'b1, 1'b0);
        chk("stop2_idle", 16'(state), 16'(IDLE));
        entry(4'd0, 4'd9, 4'd0);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("borrow_090", rem(), 16'h0089);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);

        // Door-open pause and resume at 0:30
        entry(4'd0, 4'd3, 4'd0);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        door_closed = 1'b0;
        cyc();
        chk("door_paused", 16'(state), 16'(PAUSED));
        chk("door_mag", 16'(mag_on), 16'd0);
        chk("door_lamp", 16'(lamp_on), 16'd1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("paused_tick_hold", rem(), 16'h0030);
        pulse(1'b1, 1'b0, 1'b0);
        chk("door_open_start", 16'(state), 16'(PAUSED));
        door_closed = 1'b1;
        cyc();
        chk("closed_lamp_off", 16'(lamp_on), 16'd0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_state", 16'(state), 16'(COOKING));
        chk("resume_mag", 16'(mag_on), 16'd1);
        chk("resume_rem", rem(), 16'h0030);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("abandon_idle", 16'(state), 16'(IDLE));
        chk("abandon_rem", rem(), 16'h0000);
        chk("abandon_clr", 16'(entry_clr), 16'd1);

        // Ignored starts, clamping, back-to-back clears in IDLE
        entry(4'd0, 4'd0, 4'd0);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        chk("zero_start_idle", 16'(state), 16'(IDLE));
        chk("zero_start_mag", 16'(mag_on), 16'd0);
        entry(4'd0, 4'd0, 4'd5);
        door_closed = 1'b0;
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        chk("open_start_idle", 16'(state), 16'(IDLE));
        door_closed = 1'b1;
        entry(4'hC, 4'd0, 4'hF);
        cyc();
        chk("clamp", rem(), 16'h0909);
        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_stop_clr", 16'(entry_clr), 16'd1);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("clr_not_consec", 16'(entry_clr), 16'd0);

        // Same-cycle priority: stop beats tick, resume edge ignores tick
        entry(4'd0, 4'd1, 4'd0);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("stop_tick_state", 16'(state), 16'(PAUSED));
        chk("stop_tick_rem", rem(), 16'h0010);
        pulse(1'b1, 1'b0, 1'b1);
        chk("resume_tick_state", 16'(state), 16'(COOKING));
        chk("resume_tick_rem", rem(), 16'h0010);
        pulse(1'b0, 1'b0, 1'b1);
        chk("after_resume_tick", rem(), 16'h0009);

        // Asynchronous reset mid-cook
        #3 rst = 1'b0;
        #1;
        chk("arst_mag", 16'(mag_on), 16'd0);
        chk("arst_state", 16'(state), 16'(IDLE));
        chk("arst_rem", rem(), 16'h0000);
        #2 rst = 1'b1;
        cyc();

        // Start ends the alarm early
        entry(4'd0, 4'd0, 4'd1);
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("done_001", 16'(state), 16'(DONE));
        pulse(1'b1, 1'b0, 1'b0);
        chk("early_idle", 16'(state), 16'(IDLE));
        chk("early_alarm", 16'(alarm), 16'd0);
        chk("early_clr", 16'(entry_clr), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
